// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: latches a 512-bit block and streams W_0..W_(ROUNDS-1),
// one word per adv_i, from a 16-word sliding window.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [511:0] block_i,
  input  logic         adv_i,
  output logic [31:0]  w_o,
  output logic         w_valid,
  output logic [5:0]   round_o,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_e      state_q;
  logic [31:0] win_q [16];
  logic [5:0]  t_q;
  logic [31:0] w16_d;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // win_q[j] holds W_(t+j); the new tail word is W_(t+16)
  assign w16_d = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      for (int j = 0; j < 16; j++) win_q[j] <= '0;
      t_q     <= '0;
      w_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int j = 0; j < 16; j++) win_q[j] <= block_i[511-32*j -: 32];
            t_q     <= '0;
            state_q <= RUN;
            w_valid <= 1'b1;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (adv_i) begin
            if (t_q == LAST) begin
              state_q <= DONE;
              w_valid <= 1'b0;
              done    <= 1'b1;
            end else begin
              for (int j = 0; j < 15; j++) win_q[j] <= win_q[j+1];
              win_q[15] <= w16_d;
              t_q       <= t_q + 6'd1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w_o     = win_q[0];
  assign round_o = t_q;

endmodule
